tick_gen: RTL
=============

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning the width of the divide ratio.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4, meaning the divide ratio loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: run request, level-sensitive.
REQ-006 SHALL have port div_val, input, DIV_W bits: the new divide ratio N.
REQ-007 SHALL have port div_load, input, 1 bit: request to load div_val; sampled on every clock edge.
REQ-008 SHALL have port div_ack, output, 1 bit: one-cycle pulse when the new ratio takes effect.
REQ-009 SHALL have port busy, output, 1 bit: high while a reload is pending.
REQ-010 SHALL have port tick, output, 1 bit: one-cycle pulse, once every N cycles.
REQ-011 SHALL have port phase, output, 1 bit: divided square wave that toggles on every tick.
REQ-012 SHALL have port tick_cnt, output, 32 bits: running count of ticks (see REQ-030).

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and RELOAD.
REQ-014 IDLE: tick=0 and phase=0. en=1 → RUN, with the down-counter loaded to eff_N-1.
REQ-015 eff_N SHALL be div_cur, except div_cur=0 SHALL be treated as 1.
REQ-016 RUN: the counter SHALL decrement each cycle. At 0: tick=1 on the next cycle, phase toggles, counter reloads to eff_N-1.
REQ-017 With en rising at edge k: first tick visible after edge k+N, then every N cycles. N=1 → tick continuously high from edge k+1.
REQ-018 div_load in IDLE: div_cur<=div_val at that edge; div_ack=1 for the next cycle only; state stays IDLE.
REQ-019 div_load in RUN: div_val captured into div_pend; → RELOAD; busy=1 from the next cycle.
REQ-020 RELOAD: counting continues with the old ratio. At the terminal count: div_cur<=div_pend, counter loads new eff_N-1, and div_ack pulses in the same cycle as that tick; → RUN.
REQ-021 div_load during RELOAD: div_pend SHALL be overwritten (last wins); exactly one div_ack is produced.
REQ-022 div_load coincident with the RELOAD terminal count: the new value SHALL become pending and the state stays RELOAD.
REQ-023 en=0 in RUN: → IDLE next edge; counter cleared; tick=0; phase=0.
REQ-024 en=0 in RELOAD: div_pend applied immediately; div_ack pulses; → IDLE.
REQ-025 The period SHALL never be truncated by a reload; the tick spacing is always exactly old N, then new N.

Reset
REQ-026 rst_n=0 at an edge SHALL force: state IDLE, div_cur=DEFAULT_DIV, counter=0, div_pend=0, tick=0, phase=0, div_ack=0, busy=0, tick_cnt=0.
REQ-027 Reset SHALL override en and div_load at the same edge.
REQ-028 Reset mid-RELOAD SHALL discard the pending value without producing div_ack.

Configuration
REQ-029 Macro TICK_GEN_CNT_EN SHALL compile the tick counter in or out.
REQ-030 With TICK_GEN_CNT_EN defined: tick_cnt increments on each tick, wraps 0xFFFFFFFF→0, and is not cleared by IDLE.
REQ-031 Without TICK_GEN_CNT_EN: tick_cnt is tied to 0 and no counter flops exist.

Structure
REQ-032 Package tick_gen_pkg SHALL hold the state enum, the DIV_W default and the DEFAULT_DIV default.
REQ-033 Sub-module tick_gen_cnt SHALL implement the loadable down-counter with a terminal-count flag; all other logic lives in the top.

Verification
REQ-034 Reset, then en=1, N=4: ticks at edges k+4, k+8, k+12; phase toggles 0→1→0.
REQ-035 div_val=0 then div_val=1 loaded in IDLE, then en=1: tick continuously high; phase toggles every cycle.
REQ-036 RUN with N=4, div_load div_val=2 mid-period: next tick after the remaining old count, div_ack in that same cycle, then ticks every 2 cycles.
REQ-037 Two div_load pulses (values 6 then 3) during RELOAD: single div_ack; new period 3.
REQ-038 en=0 during RELOAD with pending value 5: div_ack next cycle; IDLE; re-enable gives first tick after 5 cycles.
REQ-039 rst_n=0 mid-RELOAD: no div_ack; div_cur=4; all outputs 0. With TICK_GEN_CNT_EN, tick_cnt preloaded 0xFFFFFFFF wraps to 0 on the next tick.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and parameter defaults for the tick generator.
package tick_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RELOAD = 2'd2
    } state_t;

    localparam int unsigned TICK_GEN_DIV_W       = 16;
    localparam int unsigned TICK_GEN_DEFAULT_DIV = 4;

endpackage

// File: rtl/tick_gen_cnt.sv
// Loadable down-counter; tc flags a count of zero.
module tick_gen_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clr) begin
            count <= '0;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/tick_gen.sv
// Programmable tick generator with deferred ratio reload.
// Define TICK_GEN_CNT_EN to build in the 32-bit tick counter.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned DIV_W       = TICK_GEN_DIV_W,
    parameter int unsigned DEFAULT_DIV = TICK_GEN_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             busy,
    output logic             tick,
    output logic             phase,
    output logic [31:0]      tick_cnt
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             tick_q, tick_d;
    logic             phase_q, phase_d;
    logic             ack_q, ack_d;
    logic             cnt_load, cnt_clr, cnt_dec, cnt_tc;
    logic [DIV_W-1:0] cnt_load_val;

    // Counter preload for a ratio; a ratio of 0 behaves as 1.
    function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] n);
        return (n == '0) ? '0 : n - DIV_W'(1);
    endfunction

    tick_gen_cnt #(
        .W(DIV_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .clr      (cnt_clr),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cur_q  <= DIV_W'(DEFAULT_DIV);
            div_pend_q <= '0;
            tick_q     <= 1'b0;
            phase_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            tick_q     <= tick_d;
            phase_q    <= phase_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_cur_d    = div_cur_q;
        div_pend_d   = div_pend_q;
        tick_d       = 1'b0;
        phase_d      = phase_q;
        ack_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_clr      = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = reload_of(div_cur_q);

        case (state_q)
            IDLE: begin
                phase_d = 1'b0;
                if (div_load) begin
                    div_cur_d = div_val;
                    ack_d     = 1'b1;
                end
                if (en) begin
                    state_d      = RUN;
                    cnt_load     = 1'b1;
                    cnt_load_val = reload_of(div_load ? div_val : div_cur_q);
                end
            end
            RUN, RELOAD: begin
                if (!en) begin
                    // Leaving RUN/RELOAD: any outstanding ratio is applied now.
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                    phase_d = 1'b0;
                    if (div_load) begin
                        div_cur_d = div_val;
                        ack_d     = 1'b1;
                    end else if (state_q == RELOAD) begin
                        div_cur_d = div_pend_q;
                        ack_d     = 1'b1;
                    end
                end else begin
                    if (cnt_tc) begin
                        tick_d   = 1'b1;
                        phase_d  = ~phase_q;
                        cnt_load = 1'b1;
                        if (state_q == RELOAD) begin
                            div_cur_d    = div_pend_q;
                            cnt_load_val = reload_of(div_pend_q);
                            ack_d        = 1'b1;
                            state_d      = RUN;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                    // A load on the terminal count queues behind the one just applied.
                    if (div_load) begin
                        div_pend_d = div_val;
                        state_d    = RELOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tick    = tick_q;
    assign phase   = phase_q;
    assign div_ack = ack_q;
    assign busy    = (state_q == RELOAD);

`ifdef TICK_GEN_CNT_EN
    logic [31:0] tick_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick_d) begin
            tick_cnt_q <= tick_cnt_q + 32'd1;
        end
    end

    assign tick_cnt = tick_cnt_q;
`else
    assign tick_cnt = '0;
`endif

endmodule
